// File: rtl/s2p_pkg.sv
// rtl/s2p_pkg.sv - shared state type and default width for the serial-to-parallel deserializer
package s2p_pkg;

  localparam int S2P_DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY
  } s2p_state_t;

endpackage

// File: rtl/serial_to_parallel_if.sv
// rtl/serial_to_parallel_if.sv - serial input stream and parallel word output port bundle
interface serial_to_parallel_if #(
  parameter int WIDTH = s2p_pkg::S2P_DEFAULT_WIDTH
);

  logic             serial_i;
  logic             valid_i;
  logic             ready_i;
  logic [WIDTH-1:0] parallel_o;
  logic             valid_o;
  logic             overflow_o;
  logic             parity_err_o;

  modport master (
    output serial_i, valid_i, ready_i,
    input  parallel_o, valid_o, overflow_o, parity_err_o
  );

  modport slave (
    input  serial_i, valid_i, ready_i,
    output parallel_o, valid_o, overflow_o, parity_err_o
  );

endinterface

// File: rtl/s2p_hold_reg.sv
// rtl/s2p_hold_reg.sv - one-entry valid/ready holding register; drops and flags words arriving while full
module s2p_hold_reg #(
  parameter int DW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_valid,
  input  logic [DW-1:0] load_data,
  input  logic          ready_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  output logic          overflow_o
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_o    <= 1'b0;
      data_o     <= '0;
      overflow_o <= 1'b0;
    end else begin
      overflow_o <= 1'b0;
      if (load_valid) begin
        // A draining entry frees the slot on the same edge the new word arrives
        if (!valid_o || ready_i) begin
          data_o  <= load_data;
          valid_o <= 1'b1;
        end else begin
          overflow_o <= 1'b1;
        end
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/serial_to_parallel.sv
// rtl/serial_to_parallel.sv - LSB-first serial to WIDTH-bit word deserializer; optional even parity via S2P_PARITY_EN
module serial_to_parallel
  import s2p_pkg::*;
#(
  parameter int WIDTH = S2P_DEFAULT_WIDTH
) (
  input logic                 clk,
  input logic                 reset,
  serial_to_parallel_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  s2p_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] shift, shift_nxt;
  logic             word_done;
  logic             word_perr;
  logic [WIDTH:0]   hold_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      shift <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      shift <= shift_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    shift_nxt = shift;
    word_done = 1'b0;
    word_perr = 1'b0;
    case (state)
      IDLE: begin
        if (bus.valid_i) begin
          shift_nxt[0] = bus.serial_i;
          cnt_nxt      = CNT_W'(1);
          state_nxt    = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.valid_i) begin
          for (int i = 1; i < WIDTH; i++) begin
            if (cnt == CNT_W'(i)) shift_nxt[i] = bus.serial_i;
          end
          cnt_nxt = cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
`ifdef S2P_PARITY_EN
            state_nxt = PARITY;
`else
            word_done = 1'b1;
            cnt_nxt   = '0;
            state_nxt = IDLE;
`endif
          end
        end
      end
`ifdef S2P_PARITY_EN
      PARITY: begin
        if (bus.valid_i) begin
          word_done = 1'b1;
          word_perr = (^shift) ^ bus.serial_i;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
`endif
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  s2p_hold_reg #(
    .DW(WIDTH + 1)
  ) u_hold (
    .clk       (clk),
    .reset     (reset),
    .load_valid(word_done),
    .load_data ({word_perr, shift_nxt}),
    .ready_i   (bus.ready_i),
    .valid_o   (bus.valid_o),
    .data_o    (hold_data),
    .overflow_o(bus.overflow_o)
  );

  // Parity error bit is always 0 when parity is compiled out
  assign bus.parallel_o   = hold_data[WIDTH-1:0];
  assign bus.parity_err_o = hold_data[WIDTH];

endmodule

// File: tb/tb_serial_to_parallel.sv
// tb/tb_serial_to_parallel.sv - self-checking bench for serial_to_parallel (honours S2P_PARITY_EN)
module tb_serial_to_parallel;
  import s2p_pkg::*;

  localparam int WIDTH = S2P_DEFAULT_WIDTH;
`ifdef S2P_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  serial_to_parallel_if #(.WIDTH(WIDTH)) bus ();

  serial_to_parallel #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collect whole frames as a list of bits, then apply the holding-register rules
  bit               bits_q[$];
  logic             m_valid = 1'b0;
  logic [WIDTH-1:0] m_word = '0;
  logic             m_perr = 1'b0;
  logic             m_ovf = 1'b0;
  logic [WIDTH-1:0] mw;
  logic             mpe;
  bit               mdone;
  int               ones;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      bits_q.delete();
      m_valid = 1'b0;
      m_word  = '0;
      m_perr  = 1'b0;
      m_ovf   = 1'b0;
    end else begin
      mdone = 1'b0;
      mw    = '0;
      mpe   = 1'b0;
      m_ovf = 1'b0;
      if (bus.valid_i) begin
        bits_q.push_back(bus.serial_i);
        if (bits_q.size() == FRAME) begin
          mdone = 1'b1;
          ones  = 0;
          for (int k = 0; k < WIDTH; k++) begin
            mw   = mw + (WIDTH'(bits_q[k]) << k);
            ones = ones + int'(bits_q[k]);
          end
          if (FRAME > WIDTH) mpe = ((ones + int'(bits_q[FRAME-1])) % 2) != 0;
          bits_q.delete();
        end
      end
      if (mdone) begin
        if (!m_valid || bus.ready_i) begin
          m_valid = 1'b1;
          m_word  = mw;
          m_perr  = mpe;
        end else begin
          m_ovf = 1'b1;
        end
      end else if (m_valid && bus.ready_i) begin
        m_valid = 1'b0;
      end
    end
  end

  logic [WIDTH-1:0] exp_q[$];
  bit               track = 1'b0;
  int               ovf_cnt = 0;

  always @(negedge clk) begin
    check("valid_o", bus.valid_o, m_valid);
    check("overflow_o", bus.overflow_o, m_ovf);
    if (m_valid) begin
      check("parallel_o", bus.parallel_o, m_word);
      check("parity_err_o", bus.parity_err_o, m_perr);
    end
    if (track && bus.overflow_o) ovf_cnt++;
    if (track && bus.valid_o && bus.ready_i) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL order: got %0h expected no word", bus.parallel_o);
      end else begin
        check("order", bus.parallel_o, exp_q.pop_front());
      end
    end
  end

  task automatic send_bit(input logic b);
    @(negedge clk);
    bus.valid_i  = 1'b1;
    bus.serial_i = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.valid_i = 1'b0;
    end
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w);
    for (int k = 0; k < WIDTH; k++) send_bit(w[k]);
`ifdef S2P_PARITY_EN
    send_bit(^w);
`endif
  endtask

  logic [WIDTH-1:0] rw;

  initial begin
    bus.valid_i  = 1'b0;
    bus.serial_i = 1'b0;
    bus.ready_i  = 1'b1;
    repeat (2) @(negedge clk);
    check("reset valid_o", bus.valid_o, 0);
    check("reset parallel_o", bus.parallel_o, 0);
    check("reset overflow_o", bus.overflow_o, 0);
    check("reset parity_err_o", bus.parity_err_o, 0);
    reset = 1'b0;
    idle(1);

    // 1: 0,1,0,1 -> 4'hA
    send_word(4'hA);
    idle(1);
    check("t1 valid_o", bus.valid_o, 1);
    check("t1 parallel_o", bus.parallel_o, 4'hA);
    idle(1);
    check("t1 valid_o one cycle", bus.valid_o, 0);
    idle(1);

    // 2: gap of 3 idle cycles between bits 1 and 2
    send_bit(1'b0);
    send_bit(1'b1);
    idle(3);
    check("t2 no early valid", bus.valid_o, 0);
    send_bit(1'b0);
    send_bit(1'b1);
`ifdef S2P_PARITY_EN
    send_bit(1'b0);
`endif
    idle(1);
    check("t2 valid_o", bus.valid_o, 1);
    check("t2 parallel_o", bus.parallel_o, 4'hA);
    idle(2);

    // 3: backpressure and overflow
    bus.ready_i = 1'b0;
    send_word(4'h3);
    send_word(4'h5);
    idle(1);
    check("t3 overflow pulse", bus.overflow_o, 1);
    check("t3 held word", bus.parallel_o, 4'h3);
    check("t3 valid held", bus.valid_o, 1);
    idle(1);
    check("t3 overflow one cycle", bus.overflow_o, 0);
    check("t3 held word kept", bus.parallel_o, 4'h3);
    bus.ready_i = 1'b1;
    idle(1);
    check("t3 valid falls", bus.valid_o, 0);
    idle(1);

    // 4: reset after two bits, then 4'hC
    send_bit(1'b1);
    send_bit(1'b1);
    @(negedge clk);
    bus.valid_i = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    send_word(4'hC);
    idle(1);
    check("t4 valid_o", bus.valid_o, 1);
    check("t4 parallel_o", bus.parallel_o, 4'hC);
    idle(2);

`ifdef S2P_PARITY_EN
    // 5: parity good then bad
    for (int k = 0; k < WIDTH; k++) send_bit(k < 3);
    send_bit(1'b1);
    idle(1);
    check("t5 perr good", bus.parity_err_o, 0);
    check("t5 word good", bus.parallel_o, 4'h7);
    for (int k = 0; k < WIDTH; k++) send_bit(k < 3);
    send_bit(1'b0);
    idle(1);
    check("t5 perr bad", bus.parity_err_o, 1);
    check("t5 word bad", bus.parallel_o, 4'h7);
    idle(2);
`endif

    // 6: 32 random words back-to-back
    track = 1'b1;
    for (int i = 0; i < 32; i++) begin
      rw = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      exp_q.push_back(rw);
      send_word(rw);
    end
    idle(3);
    track = 1'b0;
    check("t6 all words delivered", exp_q.size(), 0);
    check("t6 no overflow", ovf_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
